// File: rtl/sd_pkg.sv
// Shared definitions for the SD card-side CMD responder: response encodings,
// frame lengths, CRC7 polynomial and FSM state encoding.
package sd_pkg;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_R1   = 2'd1;
  localparam logic [1:0] RESP_R2   = 2'd2;
  localparam logic [1:0] RESP_R3   = 2'd3;

  localparam int CMD_FRAME_BITS = 48;
  localparam int R1_FRAME_BITS  = 48;
  localparam int R2_FRAME_BITS  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_CHECK,
    ST_WAIT_RESP,
    ST_NCR,
    ST_TX,
    ST_RELEASE
  } sd_state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), initial value zero, one data bit per enable.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       ex_clk,
  input  logic       ex_resetn,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_bit,
  output logic [6:0] crc
);

  logic feedback;
  assign feedback = data_bit ^ crc[6];

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line: receives 48-bit commands, checks CRC7, sends R1/R2/R3.
// Optional macro SD_RESP_CRC_INJECT_EN adds crc_inject to corrupt the R1 CRC LSB.
module sd_card_cmd_responder
  import sd_pkg::*;
#(
  parameter int NCR         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic         ex_clk,
  input  logic         ex_resetn,
  input  logic         sd_clk,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         cmd_crc_err,
  output logic         resp_ready,
  input  logic         resp_valid,
  input  logic [1:0]   resp_type,
  input  logic [126:0] resp_content,
`ifdef SD_RESP_CRC_INJECT_EN
  input  logic         crc_inject,
`endif
  output logic         busy
);

  sd_state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync, cmd_sync;
  logic                   rise, fall, cmd_bit;
  logic [45:0]            rx_frame;
  logic [46:0]            rx_next;
  logic [5:0]             bit_cnt;
  logic [6:0]             rx_crc, tx_crc;
  logic [6:0]             ncr_cnt;
  logic [135:0]           tx_shift;
  logic [7:0]             tx_cnt, tx_last;
  logic                   tx_is_r1, inject_r;
  logic                   start_det, handshake, rx_last, rx_err;
  logic                   tx_in_crc, tx_bit;
  logic [2:0]             crc_idx;

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      clk_sync <= '0;
      cmd_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], sd_clk};
      cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], cmd_in};
    end
  end

  assign rise    = clk_sync[SYNC_STAGES-2] & ~clk_sync[SYNC_STAGES-1];
  assign fall    = ~clk_sync[SYNC_STAGES-2] & clk_sync[SYNC_STAGES-1];
  assign cmd_bit = cmd_sync[SYNC_STAGES-1];

  // A start bit is honoured in IDLE and, as a host retry, while waiting for card logic.
  assign start_det = rise && !cmd_bit && (state == ST_IDLE || state == ST_WAIT_RESP);
  assign handshake = (state == ST_WAIT_RESP) && resp_valid && !start_det;
  assign rx_last   = (state == ST_RX) && rise && (bit_cnt == 6'd46);
  assign rx_next   = {rx_frame, cmd_bit};
  assign rx_err    = !rx_next[46] || (rx_crc != rx_next[7:1]) || !rx_next[0];

  assign tx_in_crc = tx_is_r1 && (tx_cnt >= 8'd40) && (tx_cnt <= 8'd46);
  assign crc_idx   = 3'(8'd46 - tx_cnt);
  assign tx_bit    = tx_in_crc ? (tx_crc[crc_idx] ^ (inject_r && tx_cnt == 8'd46))
                               : tx_shift[135];

  assign resp_ready = (state == ST_WAIT_RESP);
  assign busy       = (state != ST_IDLE);

  sd_crc7 u_rx_crc (
    .ex_clk    (ex_clk),
    .ex_resetn (ex_resetn),
    .clear     (start_det),
    .enable    ((state == ST_RX) && rise && (bit_cnt < 6'd39)),
    .data_bit  (cmd_bit),
    .crc       (rx_crc)
  );

  sd_crc7 u_tx_crc (
    .ex_clk    (ex_clk),
    .ex_resetn (ex_resetn),
    .clear     (handshake),
    .enable    ((state == ST_TX) && fall && (tx_cnt < 8'd40)),
    .data_bit  (tx_shift[135]),
    .crc       (tx_crc)
  );

`ifdef SD_RESP_CRC_INJECT_EN
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      inject_r <= 1'b0;
    end else if (handshake) begin
      inject_r <= crc_inject;
    end
  end
`else
  assign inject_r = 1'b0;
`endif

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start_det) state_nxt = ST_RX;
      ST_RX:        if (rx_last) state_nxt = ST_CHECK;
      ST_CHECK:     state_nxt = cmd_crc_err ? ST_IDLE : ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (start_det) begin
          state_nxt = ST_RX;
        end else if (handshake) begin
          state_nxt = (resp_type == RESP_NONE) ? ST_IDLE : ST_NCR;
        end
      end
      ST_NCR:       if (rise && ncr_cnt <= 7'd1) state_nxt = ST_TX;
      ST_TX:        if (fall && tx_cnt == tx_last) state_nxt = ST_RELEASE;
      ST_RELEASE:   if (fall) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: receive shift/decode, response latch and bit serialiser.
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      cmd_out     <= 1'b1;
      cmd_oe      <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_index   <= 6'd0;
      cmd_arg     <= 32'd0;
      cmd_crc_err <= 1'b0;
      rx_frame    <= '0;
      bit_cnt     <= 6'd0;
      ncr_cnt     <= 7'd0;
      tx_shift    <= '0;
      tx_cnt      <= 8'd0;
      tx_last     <= 8'd0;
      tx_is_r1    <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (start_det) begin
        rx_frame <= '0;
        bit_cnt  <= 6'd0;
      end else if (state == ST_RX && rise) begin
        rx_frame <= rx_next[45:0];
        bit_cnt  <= bit_cnt + 6'd1;
        if (rx_last) begin
          cmd_valid   <= 1'b1;
          cmd_index   <= rx_next[45:40];
          cmd_arg     <= rx_next[39:8];
          cmd_crc_err <= rx_err;
        end
      end

      if (handshake) begin
        ncr_cnt  <= 7'(NCR);
        tx_cnt   <= 8'd0;
        tx_is_r1 <= (resp_type == RESP_R1);
        case (resp_type)
          RESP_R2: begin
            tx_shift <= {2'b00, 6'h3F, resp_content, 1'b1};
            tx_last  <= 8'(R2_FRAME_BITS - 1);
          end
          RESP_R3: begin
            tx_shift <= {2'b00, 6'h3F, resp_content[31:0], 7'h7F, 1'b1, 88'd0};
            tx_last  <= 8'(R1_FRAME_BITS - 1);
          end
          default: begin
            tx_shift <= {2'b00, resp_content[37:0], 7'h00, 1'b1, 88'd0};
            tx_last  <= 8'(R1_FRAME_BITS - 1);
          end
        endcase
      end

      if (state == ST_NCR && rise) begin
        ncr_cnt <= ncr_cnt - 7'd1;
      end

      if (state == ST_TX && fall) begin
        cmd_out  <= tx_bit;
        cmd_oe   <= 1'b1;
        tx_shift <= {tx_shift[134:0], 1'b0};
        tx_cnt   <= tx_cnt + 8'd1;
      end

      if (state == ST_RELEASE && fall) begin
        cmd_out <= 1'b1;
        cmd_oe  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed self-checking bench for sd_card_cmd_responder acting as the SD host.
// Define SD_RESP_CRC_INJECT_EN to also exercise the CRC injection path.
module tb_sd_card_cmd_responder;

  logic         ex_clk = 1'b0;
  logic         ex_resetn = 1'b0;
  logic         sd_clk = 1'b0;
  logic         cmd_in = 1'b1;
  logic         cmd_out, cmd_oe, cmd_valid, cmd_crc_err, resp_ready, busy;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         resp_valid = 1'b0;
  logic [1:0]   resp_type = 2'd0;
  logic [126:0] resp_content = '0;
`ifdef SD_RESP_CRC_INJECT_EN
  logic         crc_inject = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 ex_clk = ~ex_clk;
  always #40 sd_clk = ~sd_clk;

  sd_card_cmd_responder #(.NCR(2), .SYNC_STAGES(2)) dut (
    .ex_clk       (ex_clk),
    .ex_resetn    (ex_resetn),
    .sd_clk       (sd_clk),
    .cmd_in       (cmd_in),
    .cmd_out      (cmd_out),
    .cmd_oe       (cmd_oe),
    .cmd_valid    (cmd_valid),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cmd_crc_err  (cmd_crc_err),
    .resp_ready   (resp_ready),
    .resp_valid   (resp_valid),
    .resp_type    (resp_type),
    .resp_content (resp_content),
`ifdef SD_RESP_CRC_INJECT_EN
    .crc_inject   (crc_inject),
`endif
    .busy         (busy)
  );

  // Host drives each bit on the sd_clk falling edge, then waits for cmd_valid.
  task automatic send_cmd(input logic [47:0] frame, output logic got_valid);
    got_valid = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk);
      cmd_in = frame[i];
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge ex_clk);
      if (cmd_valid === 1'b1) begin
        got_valid = 1'b1;
        break;
      end
    end
  endtask

  // Host samples the CMD line just after each sd_clk rising edge.
  task automatic receive_resp(input int nbits, output logic [135:0] bits, output int gap,
                              output logic found, output logic oe_after, output logic out_after);
    bits = '0;
    gap = 0;
    found = 1'b0;
    oe_after = 1'bx;
    out_after = 1'bx;
    for (int c = 0; c < 100; c++) begin
      @(posedge sd_clk);
      #1;
      if (cmd_oe === 1'b1 && cmd_out === 1'b0) begin
        found = 1'b1;
        break;
      end
      gap++;
    end
    if (found) begin
      for (int i = 1; i < nbits; i++) begin
        @(posedge sd_clk);
        #1;
        bits = {bits[134:0], cmd_out};
      end
      @(posedge sd_clk);
      #1;
      oe_after = cmd_oe;
      out_after = cmd_out;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ex_clk);
    checks++;
    if ({cmd_out, cmd_oe, cmd_valid, cmd_crc_err, resp_ready, busy} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b expected 100000",
               {cmd_out, cmd_oe, cmd_valid, cmd_crc_err, resp_ready, busy});
    end
    checks++;
    if ({cmd_index, cmd_arg} !== 38'd0) begin
      errors++;
      $display("[TB] FAIL reset_fields got %h expected 0", {cmd_index, cmd_arg});
    end
    ex_resetn = 1'b1;
    repeat (20) @(negedge ex_clk);
    checks++;
    if ({cmd_oe, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %b expected 00", {cmd_oe, busy});
    end
  endtask

  task automatic test_cmd0();
    logic got;
    int   oe_seen;
    send_cmd(48'h40_00000000_95, got);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd0_valid got timeout expected pulse");
    end
    checks++;
    if ({cmd_index, cmd_arg, cmd_crc_err} !== {6'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL cmd0_fields got idx=%0d arg=%h err=%b expected idx=0 arg=0 err=0",
               cmd_index, cmd_arg, cmd_crc_err);
    end
    @(negedge ex_clk);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cmd0_pulse_width got %b expected 0", cmd_valid);
    end
    @(negedge ex_clk);
    checks++;
    if (resp_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd0_resp_ready got %b expected 1", resp_ready);
    end
    resp_type = 2'd0;
    resp_valid = 1'b1;
    @(negedge ex_clk);
    resp_valid = 1'b0;
    checks++;
    if ({busy, resp_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL resp_none_idle got busy=%b ready=%b expected 0 0", busy, resp_ready);
    end
    oe_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge ex_clk);
      if (cmd_oe !== 1'b0) oe_seen++;
    end
    checks++;
    if (oe_seen != 0) begin
      errors++;
      $display("[TB] FAIL resp_none_quiet got %0d driven cycles expected 0", oe_seen);
    end
  endtask

  task automatic test_crc_error();
    logic got;
    send_cmd(48'h51_00000000_57, got);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("[TB] FAIL crcerr_valid got timeout expected pulse");
    end
    checks++;
    if ({cmd_index, cmd_crc_err} !== {6'd17, 1'b1}) begin
      errors++;
      $display("[TB] FAIL crcerr_flag got idx=%0d err=%b expected idx=17 err=1",
               cmd_index, cmd_crc_err);
    end
    repeat (3) @(negedge ex_clk);
    checks++;
    if ({busy, resp_ready, cmd_oe} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL crcerr_idle got %b expected 000", {busy, resp_ready, cmd_oe});
    end
  endtask

  task automatic test_host_retry();
    logic got;
    send_cmd(48'h40_00000000_95, got);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("[TB] FAIL retry_first got timeout expected pulse");
    end
    send_cmd(48'h51_00000000_55, got);
    checks++;
    if (got !== 1'b1 || cmd_index !== 6'd17 || cmd_crc_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL retry_second got valid=%b idx=%0d err=%b expected 1 17 0",
               got, cmd_index, cmd_crc_err);
    end
    repeat (2) @(negedge ex_clk);
    resp_type = 2'd0;
    resp_valid = 1'b1;
    @(negedge ex_clk);
    resp_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL retry_idle got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_r1_response(input logic inject, input logic [47:0] expected);
    logic         got, found, oe_after, out_after;
    logic [135:0] bits;
    int           gap;
`ifdef SD_RESP_CRC_INJECT_EN
    crc_inject = inject;
`else
    if (inject) $display("[TB] note: injection requested without the optional port");
`endif
    resp_type = 2'd1;
    resp_content = 127'({6'd17, 32'h00000900});
    resp_valid = 1'b1;
    send_cmd(48'h51_00000000_55, got);
    checks++;
    if (got !== 1'b1 || cmd_crc_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r1_cmd got valid=%b err=%b expected 1 0", got, cmd_crc_err);
    end
    receive_resp(48, bits, gap, found, oe_after, out_after);
    resp_valid = 1'b0;
    checks++;
    if (found !== 1'b1 || gap != 2) begin
      errors++;
      $display("[TB] FAIL r1_ncr_gap got found=%b gap=%0d expected 1 2", found, gap);
    end
    checks++;
    if (bits[47:0] !== expected) begin
      errors++;
      $display("[TB] FAIL r1_frame got %h expected %h", bits[47:0], expected);
    end
    checks++;
    if ({oe_after, out_after} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL r1_release got oe=%b out=%b expected 0 1", oe_after, out_after);
    end
  endtask

  task automatic test_r2_response();
    logic         got, found, oe_after, out_after;
    logic [135:0] bits;
    int           gap;
    resp_type = 2'd2;
    resp_content = 127'h1;
    resp_valid = 1'b1;
    send_cmd(48'h42_00000000_4D, got);
    checks++;
    if (got !== 1'b1 || cmd_index !== 6'd2 || cmd_crc_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r2_cmd got valid=%b idx=%0d err=%b expected 1 2 0",
               got, cmd_index, cmd_crc_err);
    end
    receive_resp(136, bits, gap, found, oe_after, out_after);
    resp_valid = 1'b0;
    checks++;
    if (found !== 1'b1 || gap != 2) begin
      errors++;
      $display("[TB] FAIL r2_ncr_gap got found=%b gap=%0d expected 1 2", found, gap);
    end
    checks++;
    if (bits !== 136'h3F_0000_0000_0000_0000_0000_0000_0000_0003) begin
      errors++;
      $display("[TB] FAIL r2_frame got %h expected 3f..03", bits);
    end
    checks++;
    if ({oe_after, out_after} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL r2_release got oe=%b out=%b expected 0 1", oe_after, out_after);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic got, seen;
    resp_type = 2'd1;
    resp_content = 127'({6'd17, 32'h00000900});
    resp_valid = 1'b1;
    send_cmd(48'h51_00000000_55, got);
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge ex_clk);
      if (cmd_oe === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midtx_drive got timeout expected cmd_oe=1");
    end
    repeat (100) @(negedge ex_clk);
    #2;
    ex_resetn = 1'b0;
    #1;
    checks++;
    if ({cmd_oe, cmd_out, busy, resp_ready} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL midtx_reset got %b expected 0100", {cmd_oe, cmd_out, busy, resp_ready});
    end
    checks++;
    if ({cmd_index, cmd_arg} !== 38'd0) begin
      errors++;
      $display("[TB] FAIL midtx_fields got %h expected 0", {cmd_index, cmd_arg});
    end
    resp_valid = 1'b0;
    repeat (3) @(negedge ex_clk);
    ex_resetn = 1'b1;
    repeat (20) @(negedge ex_clk);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_cmd0();
    test_crc_error();
    test_host_retry();
    test_r1_response(1'b0, 48'h11_00000900_67);
    test_r2_response();
    test_reset_mid_tx();
`ifdef SD_RESP_CRC_INJECT_EN
    test_r1_response(1'b1, 48'h11_00000900_65);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
